// File: rtl/pin_event_fifo.sv
// rtl/pin_event_fifo.sv - timestamped pin-change event FIFO feeding DataSender
module pin_event_fifo #(
  parameter int PIN_WIDTH  = 8,
  parameter int TIME_WIDTH = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PIN_WIDTH-1:0]            pins_in,
  input  logic                            frame_done,
  output logic [TIME_WIDTH+PIN_WIDTH-1:0] data_out,
  output logic                            valid,
  output logic [DEPTH_LOG2:0]             count,
  output logic                            overflow
);

  localparam int ENTRY_WIDTH = TIME_WIDTH + PIN_WIDTH;
  localparam int DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = DEPTH[DEPTH_LOG2:0];

  logic [TIME_WIDTH-1:0]  timestamp;
  logic [PIN_WIDTH-1:0]   prev_pins;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [ENTRY_WIDTH-1:0] mem [DEPTH];

  logic change;
  logic full;
  logic pop;
  logic push;

  // A pop frees the head slot in the same edge, so a full FIFO can still take
  // an event when DataSender finishes a frame in that cycle.
  assign change = (pins_in != prev_pins);
  assign full   = (count == FULL_COUNT);
  assign pop    = frame_done && valid;
  assign push   = change && (!full || pop);

  assign valid    = (count != '0);
  assign data_out = valid ? mem[rd_ptr] : '0;

  // Free-running timestamp and previous-pin register for change detection
  always_ff @(posedge clk) begin
    if (rst) begin
      timestamp <= '0;
      prev_pins <= '0;
    end else begin
      timestamp <= timestamp + TIME_WIDTH'(1);
      prev_pins <= pins_in;
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (push && !pop) begin
        count <= count + (DEPTH_LOG2 + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (DEPTH_LOG2 + 1)'(1);
      end
      if (change && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Event storage; contents need no reset because data_out is gated by valid
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= {timestamp, pins_in};
    end
  end

endmodule

// File: tb/tb_pin_event_fifo.sv
// tb/tb_pin_event_fifo.sv - self-checking bench for pin_event_fifo
module tb_pin_event_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  pins_in;
  logic        frame_done;
  logic [39:0] data_out;
  logic        valid;
  logic [4:0]  count;
  logic        overflow;

  logic        rst8;
  logic [7:0]  pins8;
  logic        fd8;
  logic [15:0] data8;
  logic        valid8;
  logic [4:0]  count8;
  logic        ovf8;

  pin_event_fifo #(.PIN_WIDTH(8), .TIME_WIDTH(32), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .pins_in(pins_in), .frame_done(frame_done),
    .data_out(data_out), .valid(valid), .count(count), .overflow(overflow)
  );

  pin_event_fifo #(.PIN_WIDTH(8), .TIME_WIDTH(8), .DEPTH_LOG2(4)) dut8 (
    .clk(clk), .rst(rst8), .pins_in(pins8), .frame_done(fd8),
    .data_out(data8), .valid(valid8), .count(count8), .overflow(ovf8)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: event queue plus the counter value seen in the current cycle
  logic [31:0] m_time;
  logic [7:0]  m_prev;
  logic [7:0]  cur_pins;
  logic [39:0] m_q[$];
  logic        m_ovf;
  logic [7:0]  t8;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_main();
    chk("valid", {63'd0, valid}, {63'd0, m_q.size() != 0});
    chk("count", {59'd0, count}, 64'(m_q.size()));
    chk("data_out", {24'd0, data_out}, {24'd0, (m_q.size() != 0) ? m_q[0] : 40'd0});
    chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
  endtask

  task automatic step(input logic [7:0] p, input logic fd, input logic r);
    @(negedge clk);
    pins_in    = p;
    frame_done = fd;
    rst        = r;
    cur_pins   = p;
    @(posedge clk);
    #1;
    if (r) begin
      m_time = 32'd0;
      m_prev = 8'd0;
      m_q.delete();
      m_ovf  = 1'b0;
    end else begin
      if (fd && m_q.size() != 0) void'(m_q.pop_front());
      if (p != m_prev) begin
        if (m_q.size() < 16) m_q.push_back({m_time, p});
        else m_ovf = 1'b1;
      end
      m_prev = p;
      m_time = m_time + 32'd1;
    end
    check_main();
  endtask

  task automatic wait_until(input logic [31:0] t);
    for (int i = 0; i < 1000 && m_time != t; i++) step(cur_pins, 1'b0, 1'b0);
    chk("wait_until_bound", 64'(m_time), 64'(t));
  endtask

  task automatic step8(input logic [7:0] p, input logic fd, input logic r);
    @(negedge clk);
    pins8 = p;
    fd8   = fd;
    rst8  = r;
    @(posedge clk);
    #1;
    t8 = r ? 8'd0 : t8 + 8'd1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pins_in = 8'd0; frame_done = 1'b0; cur_pins = 8'd0;
    rst8 = 1'b1; pins8 = 8'd0; fd8 = 1'b0; t8 = 8'd0;
    m_time = 32'd0; m_prev = 8'd0; m_ovf = 1'b0;

    // Reset held with quiet pins
    for (int i = 0; i < 50; i++) step(8'd0, 1'b0, 1'b1);

    // Single event and pop
    wait_until(32'd5);
    step(8'hD2, 1'b0, 1'b0);
    chk("first_event", {24'd0, data_out}, {24'd0, 32'd5, 8'hD2});
    chk("first_count", {59'd0, count}, 64'd1);
    step(8'hD2, 1'b1, 1'b0);
    chk("after_pop_valid", {63'd0, valid}, 64'd0);

    // Three events, ordered pops
    wait_until(32'd10);
    step(8'h01, 1'b0, 1'b0);
    step(8'h03, 1'b0, 1'b0);
    wait_until(32'd20);
    step(8'h07, 1'b0, 1'b0);
    chk("three_count", {59'd0, count}, 64'd3);
    chk("head_10_01", {24'd0, data_out}, {24'd0, 32'd10, 8'h01});
    step(8'h07, 1'b1, 1'b0);
    chk("head_11_03", {24'd0, data_out}, {24'd0, 32'd11, 8'h03});
    step(8'h07, 1'b1, 1'b0);
    chk("head_20_07", {24'd0, data_out}, {24'd0, 32'd20, 8'h07});
    step(8'h07, 1'b1, 1'b0);
    chk("three_drained", {63'd0, valid}, 64'd0);

    // Random traffic: bursty phase then draining phase
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 1) == 0) ? 8'($urandom) : cur_pins, $urandom_range(0, 3) == 0, 1'b0);
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 4) == 0) ? 8'($urandom) : cur_pins, $urandom_range(0, 1) == 0, 1'b0);

    // Overflow: 17 changes without pops
    step(8'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 17; i++) begin
      step(8'(i), 1'b0, 1'b0);
      if (i == 16) begin
        chk("full_count", {59'd0, count}, 64'd16);
        chk("full_no_ovf", {63'd0, overflow}, 64'd0);
      end
    end
    chk("ovf_set", {63'd0, overflow}, 64'd1);
    for (int i = 0; i < 16; i++) step(8'd17, 1'b1, 1'b0);
    chk("ovf_drained", {63'd0, valid}, 64'd0);
    step(8'd17, 1'b1, 1'b0);
    chk("ovf_sticky", {63'd0, overflow}, 64'd1);

    // Full with simultaneous push and pop, then empty with both
    step(8'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) step(8'(i), 1'b0, 1'b0);
    step(8'hAA, 1'b1, 1'b0);
    chk("full_pp_count", {59'd0, count}, 64'd16);
    chk("full_pp_ovf", {63'd0, overflow}, 64'd0);
    for (int i = 0; i < 16; i++) step(8'hAA, 1'b1, 1'b0);
    step(8'h55, 1'b1, 1'b0);
    chk("empty_pp_count", {59'd0, count}, 64'd1);
    chk("empty_pp_valid", {63'd0, valid}, 64'd1);

    // Timestamp wrap and reset on the 8-bit-timestamp instance
    step8(8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 300 && t8 != 8'd255; i++) step8(8'd0, 1'b0, 1'b0);
    chk("wait8_bound", 64'(t8), 64'd255);
    step8(8'h01, 1'b0, 1'b0);
    step8(8'h01, 1'b0, 1'b0);
    step8(8'h02, 1'b0, 1'b0);
    chk("wrap_count", {59'd0, count8}, 64'd2);
    chk("wrap_head_ff", {48'd0, data8}, 64'h0000_0000_0000_FF01);
    step8(8'h02, 1'b1, 1'b0);
    chk("wrap_head_01", {48'd0, data8}, 64'h0000_0000_0000_0102);
    step8(8'h04, 1'b0, 1'b0);
    chk("pre_rst_count", {59'd0, count8}, 64'd2);
    step8(8'h05, 1'b0, 1'b1);
    chk("rst_count", {59'd0, count8}, 64'd0);
    chk("rst_valid", {63'd0, valid8}, 64'd0);
    chk("rst_ovf", {63'd0, ovf8}, 64'd0);
    chk("rst_data", {48'd0, data8}, 64'd0);
    step8(8'h06, 1'b0, 1'b0);
    chk("restart_ts", {48'd0, data8}, 64'h0000_0000_0000_0006);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
